freeze_scheduler: RTL and testbench
===================================

// Module: freeze_scheduler
// PURPOSE
//  Central game-flow sequencer in front of the frame-gating path. Decides when the game
//  world advances and when it freezes.
//  Arbitrates three freeze causes (fuel empty, crash, pause button) by fixed priority.
//  Times the crash freeze and the post-crash blinking/invulnerable respawn window.
//  Drives the gated start-of-frame, car visibility, crash sound enable and game-over flag.
// PARAMETERS
//  CLK_TICKS_PER_TENTH  5_000_000  clk cycles per 0.1 s timing unit (50 MHz clk)
//  CRASH_TENTHS         30         crash freeze length, in tenths (3.0 s)
//  BLINK_TENTHS         20         respawn blink window length, in tenths (2.0 s)
//  BLINK_HALF_TENTHS    2          car_visible toggle period, in tenths
// PORTS
//  clk              in   1  system clock
//  resetN           in   1  synchronous active-low reset
//  stratOfFrameIn   in   1  start-of-frame pulse from the VGA timing
//  crash_req        in   1  level: player car is colliding
//  fuel_empty       in   1  level: fuel counter reached zero
//  pause_btn        in   1  level: debounced pause key
//  stratOfFrameOut  out  1  gated start-of-frame to the game logic
//  car_visible      out  1  player car draw enable
//  invulnerable     out  1  collisions ignored (respawn window)
//  make_noise       out  1  crash sound enable
//  game_over        out  1  game ended; sticky until reset
//  state_code       out  3  RUN=0 CRASH=1 BLINK=2 PAUSED=3 GAMEOVER=4
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-low; resetN is sampled on posedge clk.
//  - Reset values:
//    - state RUN.
//    - stratOfFrameOut=0, car_visible=1, invulnerable=0, make_noise=0, game_over=0,
//      state_code=0.
//    - Prescaler and tenth counter = 0.
//    - pause_d = 1, so a key held through reset does not pause.
//  - All outputs are registered.
//    - stratOfFrameOut(t+1) = stratOfFrameIn(t) when state(t) is RUN or BLINK; otherwise 0.
//    - Latency is 1 cycle. Gating uses the pre-transition state.
//  - pause_rise = pause_btn & ~pause_d; pause_d updates every cycle.
//  - Timer:
//    - The prescaler counts 0..CLK_TICKS_PER_TENTH-1 and wraps; the wrap cycle is a tenth tick.
//    - The tenth counter increments on each tick.
//    - Both counters clear on every state change, so a timed state lasts exactly
//      N*CLK_TICKS_PER_TENTH cycles measured from its entry cycle.
//  - Transitions, first match wins:
//    - Any state except PAUSED/GAMEOVER, fuel_empty=1 -> GAMEOVER (highest priority).
//    - RUN, crash_req=1 -> CRASH.
//    - RUN, pause_rise -> PAUSED.
//    - CRASH, CRASH_TENTHS elapsed -> BLINK.
//    - BLINK, BLINK_TENTHS elapsed -> RUN.
//    - PAUSED, pause_rise -> RUN. fuel_empty is ignored while paused and is acted on
//      the cycle after resume.
//    - GAMEOVER is absorbing; only resetN leaves it.
//  - Outputs by state:
//    - CRASH: make_noise=1, car_visible=1, frames gated.
//    - BLINK: invulnerable=1; car_visible starts 0 on entry and toggles every
//      BLINK_HALF_TENTHS ticks. crash_req and pause_rise are ignored.
//    - RUN and PAUSED: car_visible=1.
//    - GAMEOVER: game_over=1, frames gated.
//    - make_noise and invulnerable are 0 outside their own states.
//  - Simultaneous events in RUN, same cycle: fuel_empty beats crash_req, which beats pause_rise.
//  - crash_req still high on BLINK->RUN re-enters CRASH the next cycle.
//  - Reset asserted mid-CRASH/BLINK/PAUSED: all reset values on the next edge; the timer is lost.
// TESTING  (CLK_TICKS_PER_TENTH=4, CRASH_TENTHS=3, BLINK_TENTHS=2, BLINK_HALF_TENTHS=1)
//  1 Reset, SOF pulse every 10 cycles -> stratOfFrameOut mirrors with 1-cycle delay;
//    state_code=0.
//  2 crash_req 1 cycle in RUN:
//    - CRASH for 12 cycles: make_noise=1, no SOF out.
//    - Then BLINK for 8 cycles: car_visible 0,1 toggling every 4 cycles, invulnerable=1.
//    - Then RUN.
//  3 fuel_empty and crash_req asserted in the same cycle in RUN -> GAMEOVER, game_over=1;
//    SOF blocked forever until resetN=0.
//  4 Pause sequence:
//    - pause_btn held 20 cycles -> PAUSED exactly once.
//    - fuel_empty raised while paused -> no change.
//    - Second press -> RUN for 1 cycle, then GAMEOVER.
//  5 pause_btn held high through reset release -> stays RUN. crash_req during BLINK -> ignored.
//  6 resetN=0 at cycle 5 of CRASH -> next edge: RUN, make_noise=0, counters 0; new crash
//    takes a full 12 cycles.

Source files
------------

// File: rtl/freeze_scheduler_if.sv
// Game-flow control bundle between the frame-timing/game logic and the freeze scheduler.
// The slave side is the scheduler; the master side drives the request levels and the raw SOF.
interface freeze_scheduler_if;
  logic       stratOfFrameIn;
  logic       crash_req;
  logic       fuel_empty;
  logic       pause_btn;
  logic       stratOfFrameOut;
  logic       car_visible;
  logic       invulnerable;
  logic       make_noise;
  logic       game_over;
  logic [2:0] state_code;

  modport master (
    output stratOfFrameIn, crash_req, fuel_empty, pause_btn,
    input  stratOfFrameOut, car_visible, invulnerable, make_noise, game_over, state_code
  );

  modport slave (
    input  stratOfFrameIn, crash_req, fuel_empty, pause_btn,
    output stratOfFrameOut, car_visible, invulnerable, make_noise, game_over, state_code
  );
endinterface

// File: rtl/freeze_scheduler.sv
// Game-flow sequencer: arbitrates fuel/crash/pause freezes, times crash and respawn blink.
// All outputs registered, 1-cycle latency; no backpressure (level inputs, pulse SOF).
module freeze_scheduler #(
  parameter int CLK_TICKS_PER_TENTH = 5_000_000,
  parameter int CRASH_TENTHS        = 30,
  parameter int BLINK_TENTHS        = 20,
  parameter int BLINK_HALF_TENTHS   = 2
) (
  input logic               clk,
  input logic               resetN,
  freeze_scheduler_if.slave bus
);

  localparam int PRE_W      = (CLK_TICKS_PER_TENTH > 1) ? $clog2(CLK_TICKS_PER_TENTH) : 1;
  localparam int MAX_TENTHS = (CRASH_TENTHS > BLINK_TENTHS) ? CRASH_TENTHS : BLINK_TENTHS;
  localparam int TEN_W      = (MAX_TENTHS > 1) ? $clog2(MAX_TENTHS) : 1;
  localparam int HALF_W     = (BLINK_HALF_TENTHS > 1) ? $clog2(BLINK_HALF_TENTHS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_TICKS_PER_TENTH - 1);
  localparam logic [TEN_W-1:0]  CRASH_LAST = TEN_W'(CRASH_TENTHS - 1);
  localparam logic [TEN_W-1:0]  BLINK_LAST = TEN_W'(BLINK_TENTHS - 1);
  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(BLINK_HALF_TENTHS - 1);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_CRASH    = 3'd1,
    ST_BLINK    = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [TEN_W-1:0]    tenth_q, tenth_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic                pause_d_q, pause_d_d;
  logic                sof_out_q, sof_out_d;
  logic                car_visible_q, car_visible_d;
  logic                invulnerable_q, invulnerable_d;
  logic                make_noise_q, make_noise_d;
  logic                game_over_q, game_over_d;

  logic pause_rise;
  logic tick;
  logic state_chg;
  logic blink_toggle;

  always_comb begin
    pause_rise   = bus.pause_btn & ~pause_d_q;
    tick         = (presc_q == PRE_LAST);
    pause_d_d    = bus.pause_btn;
    state_d      = state_q;

    unique case (state_q)
      ST_RUN: begin
        if (bus.fuel_empty)     state_d = ST_GAMEOVER;
        else if (bus.crash_req) state_d = ST_CRASH;
        else if (pause_rise)    state_d = ST_PAUSED;
      end
      ST_CRASH: begin
        if (bus.fuel_empty)                      state_d = ST_GAMEOVER;
        else if (tick && tenth_q == CRASH_LAST)  state_d = ST_BLINK;
      end
      ST_BLINK: begin
        if (bus.fuel_empty)                      state_d = ST_GAMEOVER;
        else if (tick && tenth_q == BLINK_LAST)  state_d = ST_RUN;
      end
      ST_PAUSED: begin
        if (pause_rise) state_d = ST_RUN;
      end
      ST_GAMEOVER: state_d = ST_GAMEOVER;
      default:     state_d = ST_RUN;
    endcase

    // Timers restart on any state change so each timed state runs from its entry cycle.
    state_chg = (state_d != state_q);
    if (state_chg || tick) presc_d = '0;
    else                   presc_d = presc_q + 1'b1;

    if (state_chg) tenth_d = '0;
    else if (tick) tenth_d = tenth_q + 1'b1;
    else           tenth_d = tenth_q;

    blink_toggle = tick && (half_q == HALF_LAST);
    if (state_chg || blink_toggle) half_d = '0;
    else if (tick)                 half_d = half_q + 1'b1;
    else                           half_d = half_q;

    car_visible_d = 1'b1;
    if (state_d == ST_BLINK) begin
      if (state_q != ST_BLINK) car_visible_d = 1'b0;
      else if (blink_toggle)   car_visible_d = ~car_visible_q;
      else                     car_visible_d = car_visible_q;
    end

    sof_out_d      = bus.stratOfFrameIn & ((state_q == ST_RUN) || (state_q == ST_BLINK));
    invulnerable_d = (state_d == ST_BLINK);
    make_noise_d   = (state_d == ST_CRASH);
    game_over_d    = (state_d == ST_GAMEOVER);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q        <= ST_RUN;
      presc_q        <= '0;
      tenth_q        <= '0;
      half_q         <= '0;
      pause_d_q      <= 1'b1;
      sof_out_q      <= 1'b0;
      car_visible_q  <= 1'b1;
      invulnerable_q <= 1'b0;
      make_noise_q   <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      tenth_q        <= tenth_d;
      half_q         <= half_d;
      pause_d_q      <= pause_d_d;
      sof_out_q      <= sof_out_d;
      car_visible_q  <= car_visible_d;
      invulnerable_q <= invulnerable_d;
      make_noise_q   <= make_noise_d;
      game_over_q    <= game_over_d;
    end
  end

  assign bus.stratOfFrameOut = sof_out_q;
  assign bus.car_visible     = car_visible_q;
  assign bus.invulnerable    = invulnerable_q;
  assign bus.make_noise      = make_noise_q;
  assign bus.game_over       = game_over_q;
  assign bus.state_code      = state_q;

endmodule

// File: tb/tb_freeze_scheduler.sv
// Bench for freeze_scheduler: directed scenarios with literal expectations plus random
// stimulus, all outputs compared every cycle against an elapsed-time reference model.
module tb_freeze_scheduler;
  localparam int TPT = 4;
  localparam int CT  = 3;
  localparam int BT  = 2;
  localparam int HT  = 1;

  localparam int M_RUN = 0, M_CRASH = 1, M_BLINK = 2, M_PAUSED = 3, M_GO = 4;

  logic clk = 1'b0;
  logic resetN;
  freeze_scheduler_if bus();

  freeze_scheduler #(
    .CLK_TICKS_PER_TENTH (TPT),
    .CRASH_TENTHS        (CT),
    .BLINK_TENTHS        (BT),
    .BLINK_HALF_TENTHS   (HT)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;
  bit sof_rand = 1'b0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raw SOF: periodic every 10 cycles in directed phases, random afterwards.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sof_rand) bus.stratOfFrameIn = ($urandom_range(0, 3) == 0);
    else          bus.stratOfFrameIn = ((cyc % 10) == 0);
  end

  // Reference model: state plus cycles elapsed since entering it.
  int m_state   = M_RUN;
  int m_k       = 0;
  bit m_pause_d = 1'b1;
  bit m_sof     = 1'b0;

  always @(posedge clk) begin : model
    int  ns;
    bit  rise;
    if (!resetN) begin
      m_state   <= M_RUN;
      m_k       <= 0;
      m_pause_d <= 1'b1;
      m_sof     <= 1'b0;
    end else begin
      rise = bus.pause_btn && !m_pause_d;
      ns   = m_state;
      if (m_state != M_PAUSED && m_state != M_GO && bus.fuel_empty) ns = M_GO;
      else if (m_state == M_RUN && bus.crash_req)                    ns = M_CRASH;
      else if (m_state == M_RUN && rise)                             ns = M_PAUSED;
      else if (m_state == M_CRASH && m_k + 1 == CT * TPT)            ns = M_BLINK;
      else if (m_state == M_BLINK && m_k + 1 == BT * TPT)            ns = M_RUN;
      else if (m_state == M_PAUSED && rise)                          ns = M_RUN;
      m_sof     <= bus.stratOfFrameIn && (m_state == M_RUN || m_state == M_BLINK);
      m_k       <= (ns == m_state) ? m_k + 1 : 0;
      m_state   <= ns;
      m_pause_d <= bus.pause_btn;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("state_code",   int'(bus.state_code),      m_state);
      chk("sof_out",      int'(bus.stratOfFrameOut), int'(m_sof));
      chk("car_visible",  int'(bus.car_visible),
          (m_state == M_BLINK) ? ((m_k / (TPT * HT)) % 2) : 1);
      chk("invulnerable", int'(bus.invulnerable),    int'(m_state == M_BLINK));
      chk("make_noise",   int'(bus.make_noise),      int'(m_state == M_CRASH));
      chk("game_over",    int'(bus.game_over),       int'(m_state == M_GO));
    end
  end

  initial begin : stim
    int cnt, len, sofc, pat, entries, prev, n, go_cnt;
    resetN = 1'b0;
    bus.crash_req = 1'b0;
    bus.fuel_empty = 1'b0;
    bus.pause_btn = 1'b0;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    chk("reset_state", int'(bus.state_code), 0);
    chk("reset_car", int'(bus.car_visible), 1);
    chk("reset_sof", int'(bus.stratOfFrameOut), 0);
    resetN = 1'b1;

    // SOF passes through in RUN
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt += int'(bus.stratOfFrameOut);
    end
    chk("sof_count_run", cnt, 4);

    // Single-cycle crash: 12 cycles CRASH, 8 cycles BLINK, back to RUN
    bus.crash_req = 1'b1;
    @(negedge clk);
    bus.crash_req = 1'b0;
    len = 0; sofc = 0;
    while (bus.state_code == 3'd1 && len < 100) begin
      if (len > 0) sofc += int'(bus.stratOfFrameOut);
      len++;
      @(negedge clk);
    end
    chk("crash_len", len, 12);
    chk("crash_sof_gated", sofc, 0);
    len = 0; pat = 0;
    while (bus.state_code == 3'd2 && len < 100) begin
      pat = ((pat << 1) | int'(bus.car_visible)) & 8'hFF;
      len++;
      @(negedge clk);
    end
    chk("blink_len", len, 8);
    chk("blink_pattern", pat, 8'b0000_1111);
    chk("after_blink", int'(bus.state_code), 0);

    // Crash held during BLINK is ignored, then re-enters CRASH right after BLINK ends
    bus.crash_req = 1'b1;
    @(negedge clk);
    bus.crash_req = 1'b0;
    len = 0;
    while (bus.state_code == 3'd1 && len < 100) begin len++; @(negedge clk); end
    chk("crash_len2", len, 12);
    len = 0;
    while (bus.state_code == 3'd2 && len < 100) begin
      if (len == 2) bus.crash_req = 1'b1;
      len++;
      @(negedge clk);
    end
    chk("blink_len_crash_ignored", len, 8);
    chk("rerun_one_cycle", int'(bus.state_code), 0);
    @(negedge clk);
    chk("recrash", int'(bus.state_code), 1);
    bus.crash_req = 1'b0;
    n = 0;
    while (bus.state_code != 3'd0 && n < 200) begin n++; @(negedge clk); end
    chk("recover_run", int'(bus.state_code), 0);

    // crash beats pause in the same cycle
    bus.crash_req = 1'b1;
    bus.pause_btn = 1'b1;
    @(negedge clk);
    chk("crash_over_pause", int'(bus.state_code), 1);
    bus.crash_req = 1'b0;
    n = 0;
    while (bus.state_code != 3'd0 && n < 200) begin n++; @(negedge clk); end
    repeat (3) @(negedge clk);
    chk("held_pause_no_rise", int'(bus.state_code), 0);
    bus.pause_btn = 1'b0;
    @(negedge clk);

    // Pause: held 20 cycles pauses once, fuel ignored, resume then GAMEOVER
    bus.pause_btn = 1'b1;
    entries = 0;
    prev = int'(bus.state_code);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.state_code == 3'd3 && prev != 3) entries++;
      prev = int'(bus.state_code);
    end
    bus.pause_btn = 1'b0;
    chk("pause_entries", entries, 1);
    chk("paused_state", int'(bus.state_code), 3);
    bus.fuel_empty = 1'b1;
    repeat (5) @(negedge clk);
    chk("paused_fuel_ignored", int'(bus.state_code), 3);
    bus.pause_btn = 1'b1;
    @(negedge clk);
    chk("resume_run", int'(bus.state_code), 0);
    @(negedge clk);
    chk("fuel_after_resume", int'(bus.state_code), 4);
    bus.pause_btn = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cnt += int'(bus.stratOfFrameOut);
    end
    chk("gameover_sof_blocked", cnt, 0);
    chk("gameover_flag", int'(bus.game_over), 1);
    bus.fuel_empty = 1'b0;
    repeat (5) @(negedge clk);
    chk("gameover_sticky", int'(bus.state_code), 4);

    // fuel beats crash and pause in the same cycle
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    bus.fuel_empty = 1'b1;
    bus.crash_req = 1'b1;
    bus.pause_btn = 1'b1;
    @(negedge clk);
    chk("fuel_priority", int'(bus.state_code), 4);
    bus.fuel_empty = 1'b0;
    bus.crash_req = 1'b0;

    // pause held through reset release does not pause
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (5) @(negedge clk);
    chk("pause_through_reset", int'(bus.state_code), 0);
    bus.pause_btn = 1'b0;
    @(negedge clk);

    // reset in cycle 5 of CRASH, then a fresh full-length crash
    bus.crash_req = 1'b1;
    @(negedge clk);
    bus.crash_req = 1'b0;
    repeat (4) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    chk("midcrash_reset_state", int'(bus.state_code), 0);
    chk("midcrash_reset_noise", int'(bus.make_noise), 0);
    resetN = 1'b1;
    @(negedge clk);
    bus.crash_req = 1'b1;
    @(negedge clk);
    bus.crash_req = 1'b0;
    len = 0;
    while (bus.state_code == 3'd1 && len < 100) begin len++; @(negedge clk); end
    chk("crash_len_after_reset", len, 12);

    // Random phase
    sof_rand = 1'b1;
    go_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (m_state == M_GO) go_cnt++;
      else                 go_cnt = 0;
      bus.crash_req  = ($urandom_range(0, 29) == 0);
      bus.fuel_empty = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 39) == 0) bus.pause_btn = ~bus.pause_btn;
      resetN = !(go_cnt > 15 || $urandom_range(0, 299) == 0);
    end
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
